tile_config_mem: RTL

TILE_CONFIG_MEM -- requirements
Module: tile_config_mem

---
 rtl/tile_config_mem.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tile_config_mem.sv
`default_nettype none
// ============================================================================
// Module   : tile_config_mem
// Purpose  : Frame-addressed configuration memory; optional readback port
//            enabled by macro CFGMEM_READBACK_EN.
// Revision : 1.0
// ============================================================================
module tile_config_mem #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 640,
    localparam int UsedFrames     = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow,
    localparam int FIW            = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic                       ConfigDone,
    output logic [15:0]                FrameWrCount
`ifdef CFGMEM_READBACK_EN
    ,
    input  logic                       RdReq,
    input  logic [FIW-1:0]             RdFrame,
    output logic [FrameBitsPerRow-1:0] RdData,
    output logic                       RdValid
`endif
);

    localparam int PW = $clog2(UsedFrames + 1);

    logic [MaxFramesPerCol-1:0] r_strobe_q;
    logic [MaxFramesPerCol-1:0] w_rise;
    logic [UsedFrames-1:0]      w_cap;
    logic [UsedFrames-1:0]      r_valid;
    logic [UsedFrames-1:0]      w_valid_nxt;
    logic [PW-1:0]              w_pop;
    logic [16:0]                w_sum;
    logic                       r_done;
    logic [15:0]                r_cnt;

`ifdef CFGMEM_READBACK_EN
    logic [FrameBitsPerRow-1:0] w_frame [UsedFrames];
`endif

    // Strobes beyond the last used frame never reach the capture vector.
    assign w_rise = FrameStrobe & ~r_strobe_q;
    assign w_cap  = w_rise[UsedFrames-1:0];

    for (genvar gf = 0; gf < UsedFrames; gf++) begin : g_frame
        localparam int LO = gf * FrameBitsPerRow;
        localparam int W  = ((NoConfigBits - LO) < FrameBitsPerRow) ? (NoConfigBits - LO)
                                                                     : FrameBitsPerRow;
        logic [W-1:0] r_data;

        always_ff @(posedge CLK) begin
            if (!resetn) begin
                r_data <= '0;
            end else if (w_cap[gf]) begin
                r_data <= FrameData[W-1:0];
            end
        end

        assign ConfigBits[LO +: W] = r_data;
`ifdef CFGMEM_READBACK_EN
        assign w_frame[gf] = FrameBitsPerRow'(r_data);
`endif
    end

    always_comb begin
        w_valid_nxt = r_valid | w_cap;
        w_pop       = '0;
        for (int i = 0; i < UsedFrames; i++) begin
            w_pop = w_pop + PW'(w_cap[i]);
        end
        w_sum = {1'b0, r_cnt} + 17'(w_pop);
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_strobe_q <= '0;
            r_valid    <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_strobe_q <= FrameStrobe;
            r_valid    <= w_valid_nxt;
            r_done     <= &w_valid_nxt;
            r_cnt      <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign ConfigBits_N = ~ConfigBits;
    assign ConfigDone   = r_done;
    assign FrameWrCount = r_cnt;

`ifdef CFGMEM_READBACK_EN
    logic [FrameBitsPerRow-1:0] w_rd_sel;
    logic [FrameBitsPerRow-1:0] r_rd_data;
    logic                       r_rd_valid;

    // Out-of-range indices fall through to zero.
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < UsedFrames; i++) begin
            if (RdFrame == FIW'(i)) begin
                w_rd_sel = w_frame[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= RdReq;
            if (RdReq) begin
                r_rd_data <= w_rd_sel;
            end
        end
    end

    assign RdData  = r_rd_data;
    assign RdValid = r_rd_valid;
`endif

endmodule
`default_nettype wire
